// File: rtl/ring_rr_arbiter_if.sv
// rtl/ring_rr_arbiter_if.sv - request/grant bundle between requesters and ring_rr_arbiter
interface ring_rr_arbiter_if #(
  parameter int N  = 3,
  parameter int IW = 2
);
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          busy;
  logic          timeout;

  // Arbiter side: consumes requests, drives the one-hot select.
  modport master (
    input  req,
    output grant,
    output grant_idx,
    output busy,
    output timeout
  );

  // Requester side.
  modport slave (
    output req,
    input  grant,
    input  grant_idx,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/ring_rr_arbiter.sv
// rtl/ring_rr_arbiter.sv - one-hot ring-pointer round-robin arbiter; optional hold watchdog under ARB_TIMEOUT_EN
module ring_rr_arbiter #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 16,
  parameter int IW       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  ring_rr_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Reject configurations the ring search and index output cannot represent.
  if (N < 2 || IW < $clog2(N) || MAX_HOLD < 1) begin : g_bad_params
    $error("ring_rr_arbiter: need N >= 2, IW >= clog2(N), MAX_HOLD >= 1");
  end

  state_t        state;
  logic [N-1:0]  ptr;
  logic [N-1:0]  grant_q;
  logic [IW-1:0] idx_q;
  logic          busy_q;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_onehot;
  logic [N-1:0]  next_ptr;
  logic          held_req;
  logic          timeout_hit;

  // Find the pointer position, then scan the ring from there for the first requester.
  always_comb begin
    int base;
    int c;
    base      = 0;
    c         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int p = 0; p < N; p++) begin
      if (ptr[p]) base = p;
    end
    for (int k = 0; k < N; k++) begin
      c = base + k;
      if (c >= N) c = c - N;
      if (!win_found && bus.req[c]) begin
        win_found = 1'b1;
        win_idx   = IW'(c);
      end
    end
  end

  // The pointer moves one past the winner so the winner drops to lowest priority.
  assign win_onehot = N'(1) << win_idx;
  assign next_ptr   = {win_onehot[N-2:0], win_onehot[N-1]};

  // Only the current owner's request matters while a grant is held.
  assign held_req = |(bus.req & grant_q);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;
  // Counter holds (granted cycles - 1), so this fires on the MAX_HOLD-th granted cycle.
  assign timeout_hit = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign bus.timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Arbitration FSM with registered grant, index, busy and timeout outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= N'(1);
      grant_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else if (flush) begin
      state   <= IDLE;
      ptr     <= N'(1);
      grant_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_found) begin
            state   <= GRANT;
            grant_q <= win_onehot;
            idx_q   <= win_idx;
            ptr     <= next_ptr;
            busy_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
`ifdef ARB_TIMEOUT_EN
          hold_cnt  <= hold_cnt + HOLD_W'(1);
          timeout_q <= timeout_hit;
`endif
          if (timeout_hit || !held_req) begin
            state   <= RELEASE;
            grant_q <= '0;
            idx_q   <= '0;
          end
        end
        RELEASE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb/tb_ring_rr_arbiter.sv - randomized bench for ring_rr_arbiter against a behavioural model
module tb_ring_rr_arbiter;
  localparam int N        = 3;
  localparam int IW       = 2;
  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush;

  ring_rr_arbiter_if #(.N(N), .IW(IW)) bus ();

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: owner = granted requester (-1 none), prio = requester with top priority,
  // cool = in the dead cycle after a grant, held = cycles the owner has been granted.
  int m_owner;
  int m_prio;
  bit m_cool;
  int m_held;
  bit m_tmo;

  logic [N-1:0] r;
  logic [N-1:0] seq_q[$];
  logic [N-1:0] prev_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_prio  = 0;
    m_cool  = 1'b0;
    m_held  = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] rq, input logic fl);
    m_tmo = 1'b0;
    if (fl) begin
      model_reset();
    end else if (m_owner >= 0) begin
      m_held++;
      if (TMO_EN && m_held >= MAX_HOLD) begin
        m_owner = -1;
        m_cool  = 1'b1;
        m_tmo   = 1'b1;
      end else if (!rq[m_owner]) begin
        m_owner = -1;
        m_cool  = 1'b1;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_prio + k) % N;
        if (m_owner < 0 && rq[c]) begin
          m_owner = c;
          m_prio  = (c + 1) % N;
          m_held  = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("grant",     32'(bus.grant),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("grant_idx", 32'(bus.grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("busy",      32'(bus.busy),      32'((m_owner >= 0) || m_cool));
    check("timeout",   32'(bus.timeout),   32'(m_tmo));
  endtask

  // One clock: the model consumes the inputs the DUT saw at the edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    model_step(bus.req, flush);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    flush   = 1'b0;
    bus.req = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    compare_all();
  endtask

  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    bus.req = '0;
    repeat (2) @(posedge clk);

    // Reset state and first grant.
    do_reset();
    bus.req = 3'b111;
    step();
    check("first_grant", 32'(bus.grant), 32'd1);

    // Owner drops after 3 granted cycles; next grant goes to requester 1 after two dead cycles.
    step();
    step();
    bus.req = 3'b110;
    repeat (4) step();
    check("second_grant", 32'(bus.grant), 32'd2);

    // Flush while requester 1 holds the grant, then restart from requester 0.
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    bus.req = 3'b111;
    step();
    check("post_flush", 32'(bus.grant), 32'd1);

    // Alternation with req=101, each owner dropping for one cycle after two granted cycles.
    do_reset();
    seq_q.delete();
    prev_grant = '0;
    for (int i = 0; i < 20; i++) begin
      r = 3'b101;
      if (m_owner >= 0 && m_held >= 1) r[m_owner] = 1'b0;
      bus.req = r;
      step();
      if (bus.grant != 0 && prev_grant == 0) seq_q.push_back(bus.grant);
      prev_grant = bus.grant;
    end
    check("alt_count", 32'(seq_q.size() >= 4), 32'd1);
    if (seq_q.size() >= 4) begin
      check("alt_0", 32'(seq_q[0]), 32'd1);
      check("alt_1", 32'(seq_q[1]), 32'd4);
      check("alt_2", 32'(seq_q[2]), 32'd1);
      check("alt_3", 32'(seq_q[3]), 32'd4);
    end

    // Asynchronous reset between edges while requester 2 holds the grant.
    flush = 1'b1;
    bus.req = '0;
    step();
    flush = 1'b0;
    bus.req = 3'b100;
    step();
    step();
    check("pre_async", 32'(bus.grant), 32'd4);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_grant", 32'(bus.grant), 32'd0);
    check("async_busy",  32'(bus.busy),  32'd0);
    #1 reset = 1'b0;

    // Continuous req=011: watchdog revokes after MAX_HOLD cycles when built in.
    do_reset();
    bus.req = 3'b011;
    repeat (14) step();

    // Randomized traffic with occasional flushes.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = bus.req;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      bus.req = r;
      flush   = ($urandom_range(0, 40) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
